d_mem_line_server: RTL

Backing-store responder for the data cache's memory-side port. It accepts line-fill reads and single-word writes from the cache controller and models programmable access latency. It returns a one-cycle completion pulse and, for reads, a full 128-bit line. It sits below the cache controller and answers that controller's read-request/write-request/completion handshake.

---
 rtl/d_mem_line_server.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/d_mem_line_server.sv
// d_mem_line_server: latency-modelled 128-bit line backing store for the data cache memory port.
// Define D_MEM_PERF_CNT_EN to add the saturating rd_cnt_o / wr_cnt_o completion counters.
module d_mem_line_server #(
  parameter int unsigned LINES  = 256,
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     r_mem_req_i,
  input  logic                     w_mem_req_i,
  input  logic [$clog2(LINES)-1:0] mem_addr_i,
  input  logic                     mem_wr_en_i,
  input  logic [31:0]              mem_wr_data_i,
  input  logic [1:0]               word_id_i,
  output logic                     mem_comp_o,
  output logic [127:0]             mem_data_o,
  output logic                     mem_busy_o
`ifdef D_MEM_PERF_CNT_EN
  ,
  output logic [15:0]              rd_cnt_o,
  output logic [15:0]              wr_cnt_o
`endif
);

  localparam int unsigned AW      = $clog2(LINES);
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  // Request fields captured on the acceptance edge
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [31:0]   data;
    logic [1:0]    word;
    logic          rd;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic          comp_q, comp_d;
  logic [127:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic          mem_we;

  logic [127:0]  mem [LINES];

`ifdef D_MEM_PERF_CNT_EN
  logic          wr_txn_q, wr_txn_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
`endif

  // State, latched request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      comp_q   <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
`ifdef D_MEM_PERF_CNT_EN
      wr_txn_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      comp_q   <= comp_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
`ifdef D_MEM_PERF_CNT_EN
      wr_txn_q <= wr_txn_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

  // Next state, latency countdown and output pre-computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    comp_d  = 1'b0;
    data_d  = data_q;
    mem_we  = 1'b0;
`ifdef D_MEM_PERF_CNT_EN
    wr_txn_d = wr_txn_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_mem_req_i || r_mem_req_i) begin
          req_d = '{addr: mem_addr_i, wr_en: mem_wr_en_i, data: mem_wr_data_i,
                    word: word_id_i, rd: r_mem_req_i};
`ifdef D_MEM_PERF_CNT_EN
          wr_txn_d = w_mem_req_i;
`endif
          if (w_mem_req_i) begin
            state_d = WR;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          mem_we = req_q.wr_en;
          if (req_q.rd) begin
            state_d = RD;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = DONE;
            comp_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD: begin
        // Any write of a combined request committed before RD was entered
        if (cnt_q == '0) begin
          state_d = DONE;
          comp_d  = 1'b1;
          data_d  = mem[req_q.addr];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef D_MEM_PERF_CNT_EN
        if (req_q.rd && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
        if (wr_txn_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end

  // Lane write into the unreset line array
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_q.addr][{req_q.word, 5'd0} +: 32] <= req_q.data;
  end

  assign mem_comp_o = comp_q;
  assign mem_data_o = data_q;
  assign mem_busy_o = busy_q;
`ifdef D_MEM_PERF_CNT_EN
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
